// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Each request runs IDLE -> EXEC -> RESP and returns its result over a valid/ready handshake.
module alu_share_arbiter #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned OP_W   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              r0_valid,
    output logic              r0_ready,
    input  logic [OP_W-1:0]   r0_op,
    input  logic [DATA_W-1:0] r0_a,
    input  logic [DATA_W-1:0] r0_b,
    output logic              r0_rvalid,
    input  logic              r0_rready,
    output logic [DATA_W-1:0] r0_result,
    input  logic              r1_valid,
    output logic              r1_ready,
    input  logic [OP_W-1:0]   r1_op,
    input  logic [DATA_W-1:0] r1_a,
    input  logic [DATA_W-1:0] r1_b,
    output logic              r1_rvalid,
    input  logic              r1_rready,
    output logic [DATA_W-1:0] r1_result,
    output logic [OP_W-1:0]   alu_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_result,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                last_grant_q, last_grant_d;
    logic                gnt_q, gnt_d;
    logic [OP_W-1:0]     op_q, op_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic                rvalid0_q, rvalid1_q, busy_q;
    logic                win0, win1, resp_taken;

    // Contention goes to the side that did not win last time.
    assign win0 = r0_valid && (!r1_valid || last_grant_q);
    assign win1 = r1_valid && (!r0_valid || !last_grant_q);
    assign resp_taken = gnt_q ? r1_rready : r0_rready;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        gnt_d        = gnt_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        result_d     = result_q;
        r0_ready     = 1'b0;
        r1_ready     = 1'b0;
        unique case (state_q)
            IDLE: begin
                r0_ready = win0;
                r1_ready = win1;
                if (win0) begin
                    op_d    = r0_op;
                    a_d     = r0_a;
                    b_d     = r0_b;
                    gnt_d   = 1'b0;
                    state_d = EXEC;
                end else if (win1) begin
                    op_d    = r1_op;
                    a_d     = r1_a;
                    b_d     = r1_b;
                    gnt_d   = 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                result_d = alu_result;
                state_d  = RESP;
            end
            RESP: begin
                if (resp_taken) begin
                    last_grant_d = gnt_q;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; response flags are registered from next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            gnt_q        <= 1'b0;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            result_q     <= '0;
            rvalid0_q    <= 1'b0;
            rvalid1_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            gnt_q        <= gnt_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            result_q     <= result_d;
            rvalid0_q    <= (state_d == RESP) && !gnt_d;
            rvalid1_q    <= (state_d == RESP) && gnt_d;
            busy_q       <= (state_d != IDLE);
        end
    end

    assign alu_op    = op_q;
    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign r0_result = result_q;
    assign r1_result = result_q;
    assign r0_rvalid = rvalid0_q;
    assign r1_rvalid = rvalid1_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a behavioural ALU on the shared port.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_alu_share_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        r0_valid, r0_ready, r0_rvalid, r0_rready;
    logic        r1_valid, r1_ready, r1_rvalid, r1_rready;
    logic [3:0]  r0_op, r1_op, alu_op;
    logic [31:0] r0_a, r0_b, r1_a, r1_b, r0_result, r1_result;
    logic [31:0] alu_a, alu_b, alu_result;
    logic        busy;
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    alu_share_arbiter dut (
        .clk(clk), .reset(reset),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_op(r0_op), .r0_a(r0_a), .r0_b(r0_b),
        .r0_rvalid(r0_rvalid), .r0_rready(r0_rready), .r0_result(r0_result),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_op(r1_op), .r1_a(r1_a), .r1_b(r1_b),
        .r1_rvalid(r1_rvalid), .r1_rready(r1_rready), .r1_result(r1_result),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
        .busy(busy)
    );

    // External ALU the arbiter drives
    always_comb begin
        alu_result = 32'h0;
        case (alu_op)
            4'b0000: alu_result = alu_a & alu_b;
            4'b0001: alu_result = alu_a | alu_b;
            4'b0010: alu_result = alu_a + alu_b;
            4'b0011: alu_result = alu_a ^ alu_b;
            4'b0100: alu_result = alu_a << alu_b[4:0];
            4'b0101: alu_result = alu_a >> alu_b[4:0];
            4'b0110: alu_result = alu_a - alu_b;
            4'b0111: alu_result = 32'($signed(alu_a) >>> alu_b[4:0]);
            4'b1000: alu_result = {31'b0, alu_a == alu_b};
            4'b1100: alu_result = {31'b0, $signed(alu_a) < $signed(alu_b)};
            default: alu_result = 32'h0;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        r0_valid = 0; r0_op = 0; r0_a = 0; r0_b = 0; r0_rready = 0;
        r1_valid = 0; r1_op = 0; r1_a = 0; r1_b = 0; r1_rready = 0;
        step(); step();
        check("rst_busy", 32'(busy), 0);
        check("rst_rvalid0", 32'(r0_rvalid), 0);
        check("rst_rvalid1", 32'(r1_rvalid), 0);
        check("rst_alu_op", 32'(alu_op), 0);
        check("rst_alu_a", alu_a, 0);
        check("rst_result", r0_result, 0);

        // Single r0 ADD
        reset = 0;
        r0_valid = 1; r0_op = 4'b0010; r0_a = 5; r0_b = 7; r0_rready = 1;
        #1 check("single_ready0", 32'(r0_ready), 1);
        check("single_ready1", 32'(r1_ready), 0);
        step();
        r0_valid = 0;
        check("single_exec_busy", 32'(busy), 1);
        check("single_exec_rvalid0", 32'(r0_rvalid), 0);
        check("single_alu_op", 32'(alu_op), 32'h2);
        check("single_alu_b", alu_b, 7);
        step();
        check("single_rvalid0", 32'(r0_rvalid), 1);
        check("single_rvalid1", 32'(r1_rvalid), 0);
        check("single_result", r0_result, 12);
        check("single_resp_busy", 32'(busy), 1);
        step();
        check("single_idle_busy", 32'(busy), 0);
        check("single_idle_rvalid0", 32'(r0_rvalid), 0);

        // Contention after reset
        reset = 1; step(); reset = 0;
        r0_valid = 1; r0_op = 4'b0110; r0_a = 3; r0_b = 5; r0_rready = 1;
        r1_valid = 1; r1_op = 4'b1100; r1_a = 32'hFFFF_FFFF; r1_b = 1; r1_rready = 1;
        #1 check("cont_ready0", 32'(r0_ready), 1);
        check("cont_ready1", 32'(r1_ready), 0);
        step();
        check("cont_exec_ready1", 32'(r1_ready), 0);
        step();
        check("cont_rvalid0", 32'(r0_rvalid), 1);
        check("cont_result0", r0_result, 32'hFFFF_FFFE);
        check("cont_rvalid1_idle", 32'(r1_rvalid), 0);
        step();
        check("cont_2nd_ready1", 32'(r1_ready), 1);
        check("cont_2nd_ready0", 32'(r0_ready), 0);
        step(); step();
        check("cont_rvalid1", 32'(r1_rvalid), 1);
        check("cont_result1", r1_result, 1);
        check("cont_rvalid0_off", 32'(r0_rvalid), 0);
        step();
        check("cont_3rd_ready0", 32'(r0_ready), 1);
        check("cont_3rd_ready1", 32'(r1_ready), 0);
        r0_valid = 0; r1_valid = 0;
        step();
        check("cont_no_accept", 32'(busy), 0);

        // r0 OR alone so the next contention favours r1
        r0_valid = 1; r0_op = 4'b0001; r0_a = 32'h0000_00F0; r0_b = 32'h0000_0F00;
        step(); r0_valid = 0;
        step();
        check("or_result", r0_result, 32'h0000_0FF0);
        step();

        // Backpressure on r1 XOR while r0 waits
        r0_valid = 1; r0_op = 4'b0000; r0_a = 32'hFF00_FF00; r0_b = 32'h0FF0_0FF0; r0_rready = 0;
        r1_valid = 1; r1_op = 4'b0011; r1_a = 32'hF0F0_F0F0; r1_b = 32'hFFFF_FFFF; r1_rready = 0;
        #1 check("bp_ready1", 32'(r1_ready), 1);
        step();
        r1_valid = 0; r1_op = 4'b0000; r1_a = 0;
        step();
        for (int i = 0; i < 4; i++) begin
            check("bp_rvalid1", 32'(r1_rvalid), 1);
            check("bp_result1", r1_result, 32'h0F0F_0F0F);
            check("bp_ready0", 32'(r0_ready), 0);
            check("bp_rvalid0", 32'(r0_rvalid), 0);
            step();
        end
        r1_rready = 1;
        step();
        r1_rready = 0;
        check("bp_after_rvalid1", 32'(r1_rvalid), 0);
        check("bp_after_ready0", 32'(r0_ready), 1);
        step(); step();
        check("and_result", r0_result, 32'h0F00_0F00);

        // Wrong-side rready while r0 is in RESP, r1 also waiting
        r1_valid = 1; r1_op = 4'b0010; r1_a = 1; r1_b = 1; r1_rready = 1; r0_valid = 0;
        for (int i = 0; i < 3; i++) begin
            check("ws_rvalid0", 32'(r0_rvalid), 1);
            check("ws_rvalid1", 32'(r1_rvalid), 0);
            check("ws_ready1", 32'(r1_ready), 0);
            step();
        end
        r0_rready = 1; r0_valid = 1;
        step();
        check("ws_rr_ready1", 32'(r1_ready), 1);
        check("ws_rr_ready0", 32'(r0_ready), 0);

        // Reset during EXEC of r0 SRA
        r1_valid = 0; r0_op = 4'b0111; r0_a = 32'h8000_0000; r0_b = 4;
        #1 check("sra_ready0", 32'(r0_ready), 1);
        step();
        r0_valid = 0;
        check("sra_alu_op", 32'(alu_op), 32'h7);
        check("sra_alu_a", alu_a, 32'h8000_0000);
        reset = 1;
        #1 check("mid_rst_alu_op", 32'(alu_op), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_result", r0_result, 0);
        for (int i = 0; i < 2; i++) begin
            step();
            check("mid_rst_rvalid0", 32'(r0_rvalid), 0);
        end
        reset = 0;
        r1_valid = 1; r1_op = 4'b0010; r1_a = 1; r1_b = 2; r1_rready = 1;
        #1 check("post_rst_ready1", 32'(r1_ready), 1);
        step();
        r1_valid = 0;
        check("post_rst_rvalid0", 32'(r0_rvalid), 0);
        step();
        check("post_rst_rvalid1", 32'(r1_rvalid), 1);
        check("post_rst_result", r1_result, 3);
        check("post_rst_rvalid0b", 32'(r0_rvalid), 0);
        step();
        check("post_rst_idle", 32'(busy), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
